// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
//   slave  modport : used by fetch_stage (receives Stall/Flush/Branch/
//                    BranchTarget/ImemData, drives ImemAddr and IF/ID outputs)
//   master modport : used by the surrounding core or a bench
// Optional macro FETCH_CNT_EN adds the FetchCount signal.
interface fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] InstrOut;
  logic [5:0]  OpCode;
  logic [31:0] PCPlus4Out;
  logic        ValidOut;
`ifdef FETCH_CNT_EN
  logic [31:0] FetchCount;
`endif

  modport slave (
    input  Stall, Flush, Branch, BranchTarget, ImemData,
    output ImemAddr, InstrOut, OpCode, PCPlus4Out, ValidOut
`ifdef FETCH_CNT_EN
    , output FetchCount
`endif
  );

  modport master (
    output Stall, Flush, Branch, BranchTarget, ImemData,
    input  ImemAddr, InstrOut, OpCode, PCPlus4Out, ValidOut
`ifdef FETCH_CNT_EN
    , input FetchCount
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage: holds the PC, presents it to an asynchronous-read
// instruction memory and registers the fetched word into the IF/ID register.
// Ports:
//   Clk      : rising-edge clock
//   Rst      : synchronous active-low reset
//   bus      : fetch_stage_if.slave (Stall, Flush, Branch, BranchTarget,
//              ImemData in; ImemAddr, InstrOut, OpCode, PCPlus4Out,
//              ValidOut [, FetchCount] out)
//   StateOut : debug view of the BOOT/RUN/HOLD state
// Optional macro FETCH_CNT_EN: adds a 32-bit counter of instructions accepted
// into IF/ID, driven on bus.FetchCount.
//
// Control priority on every non-reset edge: Branch > Flush > Stall > advance.
// The state does not change the rules; it only records whether a stall is in
// progress (HOLD) and marks the first cycle after reset (BOOT).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          Clk,
  input  logic          Rst,
  fetch_stage_if.slave  bus,
  output logic [1:0]    StateOut
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        capture;

  // Modulo-2^32 add: 32'hFFFF_FFFC wraps to zero silently.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    capture = 1'b0;
    if (bus.Branch) begin
      // Redirect wins over Flush and Stall; IF/ID gets a bubble.
      pc_d    = bus.BranchTarget & ~32'd3;
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (bus.Flush) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (bus.Stall) begin
        state_d = HOLD;
      end else begin
        pc_d    = pc_plus4;
        state_d = RUN;
      end
    end else if (bus.Stall) begin
      state_d = HOLD;
    end else begin
      capture = 1'b1;
      pc_d    = pc_plus4;
      instr_d = bus.ImemData;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;

  assign fcnt_d = capture ? fcnt_q + 32'd1 : fcnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fcnt_q <= 32'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign bus.FetchCount = fcnt_q;
`else
  logic capture_unused;
  assign capture_unused = capture;
`endif

  assign bus.ImemAddr   = pc_q;
  assign bus.InstrOut   = instr_q;
  assign bus.OpCode     = instr_q[31:26];
  assign bus.PCPlus4Out = pc4_q;
  assign bus.ValidOut   = valid_q;
  assign StateOut       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Table-driven bench for fetch_stage. Instruction memory is modelled as
// word(addr). A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap.
module tb_fetch_stage;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Rst;
  logic Rst2;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg2;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  assign bus.ImemData  = word(bus.ImemAddr);
  assign bus2.ImemData = word(bus2.ImemAddr);

  fetch_stage dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus),
    .StateOut (state_dbg)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk      (Clk),
    .Rst      (Rst2),
    .bus      (bus2),
    .StateOut (state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [31:0] exp_pc4;
    logic [1:0]  exp_state;
    logic [31:0] exp_fc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic b, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic v, input logic [31:0] p4,
                              input logic [1:0] st, input logic [31:0] fc);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.branch = b; x.target = t;
    x.exp_pc = pc; x.exp_instr = ins; x.exp_valid = v; x.exp_pc4 = p4;
    x.exp_state = st; x.exp_fc = fc;
    return x;
  endfunction

  task automatic check_main(input string tag, input vec_t x);
    chk({tag, ".pc"},    bus.ImemAddr, x.exp_pc);
    chk({tag, ".instr"}, bus.InstrOut, x.exp_instr);
    chk({tag, ".opcode"}, {26'd0, bus.OpCode}, {26'd0, x.exp_instr[31:26]});
    chk({tag, ".pc4"},   bus.PCPlus4Out, x.exp_pc4);
    chk({tag, ".valid"}, {31'd0, bus.ValidOut}, {31'd0, x.exp_valid});
    chk({tag, ".state"}, {30'd0, state_dbg}, {30'd0, x.exp_state});
`ifdef FETCH_CNT_EN
    chk({tag, ".fcnt"},  bus.FetchCount, x.exp_fc);
`endif
  endtask

  vec_t v[28];

  initial begin
    // fields: rst stall flush branch target | pc instr valid pc4 state fcnt
    v[0]  = mk(1,0,0,0,0,        32'h04,  word(32'h00),  1, 32'h04,  S_RUN,  1);
    v[1]  = mk(1,0,0,0,0,        32'h08,  word(32'h04),  1, 32'h08,  S_RUN,  2);
    v[2]  = mk(1,0,0,0,0,        32'h0C,  word(32'h08),  1, 32'h0C,  S_RUN,  3);
    v[3]  = mk(1,0,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_RUN,  4);
    v[4]  = mk(1,1,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_HOLD, 4);
    v[5]  = mk(1,1,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_HOLD, 4);
    v[6]  = mk(1,1,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_HOLD, 4);
    v[7]  = mk(1,0,0,0,0,        32'h14,  word(32'h10),  1, 32'h14,  S_RUN,  5);
    v[8]  = mk(1,0,0,0,0,        32'h18,  word(32'h14),  1, 32'h18,  S_RUN,  6);
    v[9]  = mk(1,0,0,0,0,        32'h1C,  word(32'h18),  1, 32'h1C,  S_RUN,  7);
    v[10] = mk(1,0,0,0,0,        32'h20,  word(32'h1C),  1, 32'h20,  S_RUN,  8);
    v[11] = mk(1,0,0,1,32'h103,  32'h100, NOP,           0, 32'h0,   S_RUN,  8);
    v[12] = mk(1,0,0,0,0,        32'h104, word(32'h100), 1, 32'h104, S_RUN,  9);
    v[13] = mk(1,1,0,1,32'h40,   32'h40,  NOP,           0, 32'h0,   S_RUN,  9);
    v[14] = mk(1,0,0,0,0,        32'h44,  word(32'h40),  1, 32'h44,  S_RUN,  10);
    v[15] = mk(1,1,1,0,0,        32'h44,  NOP,           0, 32'h0,   S_HOLD, 10);
    v[16] = mk(1,0,0,0,0,        32'h48,  word(32'h44),  1, 32'h48,  S_RUN,  11);
    v[17] = mk(1,0,1,1,32'h8,    32'h08,  NOP,           0, 32'h0,   S_RUN,  11);
    v[18] = mk(1,0,1,0,0,        32'h0C,  NOP,           0, 32'h0,   S_RUN,  11);
    v[19] = mk(1,0,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_RUN,  12);
    v[20] = mk(1,1,0,0,0,        32'h10,  word(32'h0C),  1, 32'h10,  S_HOLD, 12);
    v[21] = mk(1,1,0,1,32'h201,  32'h200, NOP,           0, 32'h0,   S_RUN,  12);
    v[22] = mk(1,0,0,0,0,        32'h204, word(32'h200), 1, 32'h204, S_RUN,  13);
    v[23] = mk(1,1,0,0,0,        32'h204, word(32'h200), 1, 32'h204, S_HOLD, 13);
    v[24] = mk(0,1,0,0,0,        32'h0,   NOP,           0, 32'h0,   S_BOOT, 0);
    v[25] = mk(0,0,1,1,32'h80,   32'h0,   NOP,           0, 32'h0,   S_BOOT, 0);
    v[26] = mk(1,1,0,0,0,        32'h0,   NOP,           0, 32'h0,   S_HOLD, 0);
    v[27] = mk(1,0,0,0,0,        32'h04,  word(32'h00),  1, 32'h04,  S_RUN,  1);

    Rst = 1'b0;
    Rst2 = 1'b0;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Branch = 1'b0; bus.BranchTarget = 32'd0;
    bus2.Stall = 1'b0; bus2.Flush = 1'b0; bus2.Branch = 1'b0; bus2.BranchTarget = 32'd0;

    // Drive garbage control inputs during reset: reset must override them.
    bus.Branch = 1'b1; bus.BranchTarget = 32'h1234;
    step();
    bus.Branch = 1'b0;
    step();
    check_main("reset", mk(0,0,0,0,0, 32'h0, NOP, 0, 32'h0, S_BOOT, 0));

    for (int i = 0; i < 28; i++) begin
      Rst              = v[i].rst_n;
      bus.Stall        = v[i].stall;
      bus.Flush        = v[i].flush;
      bus.Branch       = v[i].branch;
      bus.BranchTarget = v[i].target;
      step();
      check_main($sformatf("vec%0d", i), v[i]);
    end
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Branch = 1'b0;

    // PC wrap: RESET_PC = 32'hFFFF_FFFC instance.
    chk("wrap.reset_pc", bus2.ImemAddr, 32'hFFFF_FFFC);
    chk("wrap.reset_valid", {31'd0, bus2.ValidOut}, 32'd0);
    Rst2 = 1'b1;
    step();
    chk("wrap.pc", bus2.ImemAddr, 32'h0);
    chk("wrap.pc4", bus2.PCPlus4Out, 32'h0);
    chk("wrap.instr", bus2.InstrOut, word(32'hFFFF_FFFC));
    chk("wrap.valid", {31'd0, bus2.ValidOut}, 32'd1);
    chk("wrap.state", {30'd0, state_dbg2}, {30'd0, S_RUN});
    step();
    chk("wrap.pc_next", bus2.ImemAddr, 32'h4);
    chk("wrap.instr_next", bus2.InstrOut, word(32'h0));
    chk("wrap.pc4_next", bus2.PCPlus4Out, 32'h4);

    // Boot cycle with Stall then release: no lost or duplicated fetch.
    Rst2 = 1'b0;
    step();
    chk("boot.pc_reset", bus2.ImemAddr, 32'hFFFF_FFFC);
    Rst2 = 1'b1;
    bus2.Stall = 1'b1;
    step();
    chk("boot.stall_state", {30'd0, state_dbg2}, {30'd0, S_HOLD});
    chk("boot.stall_pc", bus2.ImemAddr, 32'hFFFF_FFFC);
    bus2.Stall = 1'b0;
    step();
    chk("boot.release_instr", bus2.InstrOut, word(32'hFFFF_FFFC));
    chk("boot.release_state", {30'd0, state_dbg2}, {30'd0, S_RUN});
`ifdef FETCH_CNT_EN
    chk("boot.release_fcnt", bus2.FetchCount, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
